// File: rtl/tone_period_detector.sv
// -----------------------------------------------------------------------------
// tone_period_detector
//
// Measures the period of a square wave on tone_in, folds it into the octave
// around C4..B4 and classifies it as one of 12 chromatic notes plus an octave.
// All period constants assume a 100 MHz clk.
//
// Parameters
//   SYNC_STAGES  flops in the tone_in synchroniser (>= 2)
//   MATCH_COUNT  consecutive identical classifications needed before the
//                outputs are updated (>= 1)
//
// Ports
//   clk          100 MHz system clock
//   rst_n        asynchronous active-low reset
//   tone_in      asynchronous square-wave input
//   note         0 = C ... 11 = B
//   octave       octave number 2..7 (C4 = 261.63 Hz)
//   note_valid   note/octave hold a confirmed classification
//   note_strobe  one-cycle pulse whenever note/octave/note_valid are written
//   period       last raw measured period in clk cycles
// -----------------------------------------------------------------------------
module tone_period_detector #(
  parameter int SYNC_STAGES = 2,
  parameter int MATCH_COUNT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tone_in,
  output logic [3:0]  note,
  output logic [2:0]  octave,
  output logic        note_valid,
  output logic        note_strobe,
  output logic [19:0] period
);

  localparam logic [19:0] CNT_MAX    = 20'd1048575;
  localparam logic [19:0] MIN_PERIOD = 20'd24590;   // shorter = glitch
  localparam logic [22:0] NORM_HI    = 23'd393432;  // reference octave bounds
  localparam logic [22:0] NORM_LO    = 23'd196716;

  // Note boundaries inside the reference octave, from C/C# down to A#/B.
  localparam logic [22:0] THRESH [0:10] = '{
    23'd371338, 23'd350509, 23'd330838, 23'd312261, 23'd294736, 23'd278195,
    23'd262586, 23'd247842, 23'd233937, 23'd220805, 23'd208414
  };

  localparam int          MC_W   = $clog2(MATCH_COUNT + 1);
  localparam logic [MC_W-1:0] MC_MAX = MC_W'(MATCH_COUNT);

  typedef enum logic [1:0] {
    WAIT_FIRST,
    MEASURE,
    NORM,
    CLASSIFY
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   edge_q;
  logic                   edge_r;     // registered one-cycle rising-edge pulse
  logic [19:0]            cnt;
  logic [22:0]            work;
  logic [2:0]             oct;
  logic [3:0]             prev_note;
  logic [2:0]             prev_oct;
  logic [MC_W-1:0]        mc;

  logic [3:0]             cand_note;
  logic                   same_cand;
  logic [MC_W-1:0]        mc_next;

  // ---------------------------------------------------------------------------
  // Synchroniser and edge detector
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, giving a true shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      edge_q <= 1'b0;
      edge_r <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], tone_in};
      edge_q <= sync_q[SYNC_STAGES-1];
      edge_r <= sync_q[SYNC_STAGES-1] & ~edge_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Period counter: restarts at 1 on every edge, saturates at full scale
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (edge_r) begin
      cnt <= 20'd1;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + 20'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Classification of the normalised period
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    cand_note = 4'd0;
    for (int k = 0; k < 11; k++) begin
      if (work < THRESH[k]) cand_note = cand_note + 4'd1;
    end
    same_cand = (cand_note == prev_note) && (oct == prev_oct);
    mc_next   = MC_W'(1);
    if (same_cand) mc_next = (mc == MC_MAX) ? mc : mc + MC_W'(1);
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= WAIT_FIRST;
      period      <= '0;
      work        <= '0;
      oct         <= '0;
      prev_note   <= '0;
      prev_oct    <= '0;
      mc          <= '0;
      note        <= '0;
      octave      <= '0;
      note_valid  <= 1'b0;
      note_strobe <= 1'b0;
    end else begin
      note_strobe <= 1'b0;
      case (state)
        WAIT_FIRST: begin
          // The first edge only starts a measurement.
          if (edge_r) state <= MEASURE;
        end

        MEASURE: begin
          if (edge_r) begin
            period <= cnt;
            if (cnt < MIN_PERIOD) begin
              mc          <= '0;
              note_valid  <= 1'b0;
              note_strobe <= 1'b1;
            end else begin
              work  <= {3'b000, cnt};
              oct   <= 3'd4;
              state <= NORM;
            end
          end else if (cnt == CNT_MAX) begin
            // Input has gone silent: drop the note and resynchronise.
            mc          <= '0;
            note_valid  <= 1'b0;
            note_strobe <= 1'b1;
            state       <= WAIT_FIRST;
          end
        end

        NORM: begin
          // Halving the period raises the pitch one octave, so a long period
          // shifted right means a lower octave number.
          if (work >= NORM_HI) begin
            work <= work >> 1;
            oct  <= oct - 3'd1;
          end else if (work < NORM_LO) begin
            work <= work << 1;
            oct  <= oct + 3'd1;
          end else begin
            state <= CLASSIFY;
          end
        end

        CLASSIFY: begin
          prev_note <= cand_note;
          prev_oct  <= oct;
          mc        <= mc_next;
          if (mc_next == MC_MAX) begin
            note        <= cand_note;
            octave      <= oct;
            note_valid  <= 1'b1;
            note_strobe <= 1'b1;
          end
          state <= MEASURE;
        end

        default: state <= WAIT_FIRST;
      endcase
    end
  end

endmodule
